// File: rtl/adding_machine_sequencer_if.sv
// Bundle of control, ROM and ALU signals for the adding machine sequencer.
// The sequencer uses the slave view; the host/ROM/ALU side uses the master view.
interface adding_machine_sequencer_if #(
  parameter int unsigned IdxW  = 30,
  parameter int unsigned CntW  = 16,
  parameter int unsigned DataW = 32
) ();
  logic             start;
  logic             abort;
  logic [IdxW-1:0]  base_index;
  logic [CntW-1:0]  length;
  logic [IdxW-1:0]  rom_index;
  logic [DataW-1:0] rom_data;
  logic [DataW-1:0] alu_a;
  logic [DataW-1:0] alu_b;
  logic [2:0]       alu_op;
  logic [DataW-1:0] alu_out;
  logic             busy;
  logic             done;
  logic [DataW-1:0] result;
  logic             carry;

  modport slave (
    input  start, abort, base_index, length, rom_data, alu_out,
    output rom_index, alu_a, alu_b, alu_op, busy, done, result, carry
  );

  modport master (
    output start, abort, base_index, length, rom_data, alu_out,
    input  rom_index, alu_a, alu_b, alu_op, busy, done, result, carry
  );
endinterface

// File: rtl/adding_machine_sequencer.sv
// Run controller for the ROM-fed accumulate datapath: walks a word range, stages each ROM word
// one cycle and folds it into the accumulator through the external ALU.
module adding_machine_sequencer #(
  parameter int unsigned IdxW     = 30,
  parameter int unsigned CntW     = 16,
  parameter int unsigned DataW    = 32,
  parameter logic [2:0]  AluAddOp = 3'b000
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  adding_machine_sequencer_if.slave   bus
);

  typedef enum logic [1:0] {StIdle, StFetch, StDrain, StDone} state_e;

  state_e           state_q, state_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic [CntW-1:0]  remaining_q, remaining_d;
  logic [DataW-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic [DataW-1:0] acc_q, acc_d;
  logic             carry_q, carry_d;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      remaining_q <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      acc_q       <= '0;
      carry_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      remaining_q <= remaining_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      acc_q       <= acc_d;
      carry_q     <= carry_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    remaining_d = remaining_q;
    data_d      = data_q;
    valid_d     = valid_q;
    acc_d       = acc_q;
    carry_d     = carry_q;

    // Staged word is folded in on every edge it is valid, including an abort edge.
    if (valid_q) begin
      acc_d   = bus.alu_out;
      carry_d = carry_q | (bus.alu_out < acc_q);
    end

    unique case (state_q)
      StIdle, StDone: begin
        if (bus.start) begin
          acc_d   = '0;
          carry_d = 1'b0;
          if (bus.length != '0) begin
            idx_d       = bus.base_index;
            remaining_d = bus.length;
            valid_d     = 1'b0;
            state_d     = StFetch;
          end else begin
            state_d = StDone;
          end
        end else if (state_q == StDone) begin
          state_d = StIdle;
        end
      end
      StFetch: begin
        if (bus.abort) begin
          valid_d = 1'b0;
          state_d = StIdle;
        end else begin
          data_d      = bus.rom_data;
          valid_d     = 1'b1;
          idx_d       = idx_q + IdxW'(1);
          remaining_d = remaining_q - CntW'(1);
          if (remaining_q == CntW'(1)) begin
            state_d = StDrain;
          end
        end
      end
      StDrain: begin
        valid_d = 1'b0;
        state_d = bus.abort ? StIdle : StDone;
      end
      default: state_d = StIdle;
    endcase
  end

  assign bus.rom_index = idx_q;
  assign bus.alu_a     = data_q;
  assign bus.alu_b     = acc_q;
  assign bus.alu_op    = AluAddOp;
  assign bus.busy      = (state_q == StFetch) || (state_q == StDrain);
  assign bus.done      = (state_q == StDone);
  assign bus.result    = acc_q;
  assign bus.carry     = carry_q;

endmodule

// File: tb/tb_adding_machine_sequencer.sv
// Directed and randomized runs of the sequencer against a sum-over-ROM reference model.
module tb_adding_machine_sequencer;
  localparam int unsigned IdxW  = 30;
  localparam int unsigned CntW  = 16;
  localparam int unsigned DataW = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  adding_machine_sequencer_if #(.IdxW(IdxW), .CntW(CntW), .DataW(DataW)) bus ();

  adding_machine_sequencer #(.IdxW(IdxW), .CntW(CntW), .DataW(DataW)) dut (
    .clk_i   (clk),
    .reset_i (rst),
    .bus     (bus)
  );

  // ROM is 16 words repeated across the whole index space; ALU is a plain adder.
  logic [31:0] rom_tab [16];
  assign bus.rom_data = rom_tab[bus.rom_index[3:0]];
  assign bus.alu_out  = bus.alu_a + bus.alu_b;

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Unwrapped sum of n consecutive ROM words; carry is set iff it reaches 2^32.
  function automatic logic [63:0] ref_sum(input logic [29:0] b, input int n);
    logic [63:0] s;
    logic [29:0] ix;
    s = '0;
    for (int k = 0; k < n; k++) begin
      ix = b + 30'(k);
      s  = s + 64'(rom_tab[ix[3:0]]);
    end
    return s;
  endfunction

  task automatic fill_random();
    for (int i = 0; i < 16; i++) rom_tab[i] = $urandom;
  endtask

  task automatic do_run(input string tag, input logic [29:0] b, input logic [15:0] len);
    logic [63:0] s;
    logic [29:0] e_idx;
    logic [29:0] idx_before;
    int busy_n, done_c, idx_bad, exp_c;
    busy_n = 0; done_c = -1; idx_bad = 0;
    exp_c = (len == 0) ? 0 : int'(len) + 1;
    @(negedge clk);
    idx_before     = bus.rom_index;
    bus.base_index = b;
    bus.length     = len;
    bus.start      = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int c = 0; c < int'(len) + 8 && done_c < 0; c++) begin
      if (c > 0) @(negedge clk);
      if (bus.busy) busy_n++;
      if (c < int'(len)) begin
        e_idx = b + 30'(c);
        if (bus.rom_index !== e_idx) idx_bad++;
      end
      if (bus.done) done_c = c;
    end
    s = ref_sum(b, int'(len));
    check({tag, ".done_cycle"}, 64'(done_c), 64'(exp_c));
    check({tag, ".busy_cycles"}, 64'(busy_n), 64'(exp_c));
    check({tag, ".rom_index_seq"}, 64'(idx_bad), 64'd0);
    check({tag, ".result"}, 64'(bus.result), {32'd0, s[31:0]});
    check({tag, ".carry"}, 64'(bus.carry), 64'(|s[63:32]));
    if (len == 0) check({tag, ".rom_index_held"}, 64'(bus.rom_index), 64'(idx_before));
    @(negedge clk);
    check({tag, ".done_single"}, 64'(bus.done), 64'd0);
  endtask

  initial begin
    logic [63:0] s;
    logic [29:0] b1, b2;
    logic [15:0] l1, l2;
    int c1, c2, gap_ok, done_seen;

    for (int i = 0; i < 16; i++) rom_tab[i] = 32'(i + 1);
    bus.start = 1'b0; bus.abort = 1'b0; bus.base_index = '0; bus.length = '0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("reset.busy", 64'(bus.busy), 64'd0);
    check("reset.done", 64'(bus.done), 64'd0);
    check("reset.result", 64'(bus.result), 64'd0);
    check("reset.carry", 64'(bus.carry), 64'd0);
    check("reset.rom_index", 64'(bus.rom_index), 64'd0);
    check("reset.alu_a", 64'(bus.alu_a), 64'd0);
    check("alu_op_add", 64'(bus.alu_op), 64'd0);
    rst = 1'b0;

    // ROM[i]=i+1, four words: 1+2+3+4.
    do_run("basic4", 30'd0, 16'd4);
    check("basic4.result_const", 64'(bus.result), 64'd10);
    do_run("len0", 30'd0, 16'd0);

    fill_random();
    do_run("wrap_idx", 30'h3FFFFFFE, 16'd4);

    rom_tab[0] = 32'hFFFF_FFFF; rom_tab[1] = 32'h2;
    do_run("carry_set", 30'd0, 16'd2);
    check("carry_set.const", 64'({bus.carry, bus.result}), {31'd0, 1'b1, 32'h1});
    for (int i = 0; i < 16; i++) rom_tab[i] = 32'(i * 3);
    do_run("carry_clr", 30'd5, 16'd3);

    for (int r = 0; r < 6; r++) begin
      fill_random();
      do_run($sformatf("rand%0d", r), 30'($urandom), 16'($urandom_range(1, 20)));
    end

    // Abort sampled on the third edge after start: two words already folded in.
    fill_random();
    b1 = 30'($urandom);
    @(negedge clk);
    bus.base_index = b1; bus.length = 16'd8; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    s = ref_sum(b1, 2);
    check("abort.busy", 64'(bus.busy), 64'd0);
    check("abort.result", 64'(bus.result), {32'd0, s[31:0]});
    check("abort.carry", 64'(bus.carry), 64'(|s[63:32]));
    done_seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.done || bus.busy) done_seen++;
    end
    check("abort.no_done", 64'(done_seen), 64'd0);

    // Start held through a run: DONE re-launches with whatever is on the inputs then.
    fill_random();
    b1 = 30'($urandom); l1 = 16'($urandom_range(2, 10));
    b2 = 30'($urandom); l2 = 16'($urandom_range(2, 10));
    @(negedge clk);
    bus.base_index = b1; bus.length = l1; bus.start = 1'b1;
    @(negedge clk);
    bus.base_index = b2; bus.length = l2;
    c1 = -1; c2 = -1; gap_ok = 0;
    for (int c = 0; c < 60 && c2 < 0; c++) begin
      if (c > 0) @(negedge clk);
      if (c1 >= 0 && c == c1 + 1) begin
        if (bus.busy) gap_ok = 1;
        bus.start = 1'b0;
      end
      if (bus.done) begin
        if (c1 < 0) begin
          c1 = c;
          s = ref_sum(b1, int'(l1));
          check("held.run1_result", 64'(bus.result), {32'd0, s[31:0]});
        end else begin
          c2 = c;
          s = ref_sum(b2, int'(l2));
          check("held.run2_result", 64'(bus.result), {32'd0, s[31:0]});
        end
      end
    end
    bus.start = 1'b0;
    check("held.run1_cycle", 64'(c1), 64'(int'(l1) + 1));
    check("held.no_idle_gap", 64'(gap_ok), 64'd1);
    check("held.run2_cycle", 64'(c2 - c1), 64'(int'(l2) + 2));

    // Asynchronous reset between edges mid-FETCH.
    fill_random();
    @(negedge clk);
    bus.base_index = 30'd3; bus.length = 16'd6; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("areset.busy", 64'(bus.busy), 64'd0);
    check("areset.result", 64'(bus.result), 64'd0);
    check("areset.rom_index", 64'(bus.rom_index), 64'd0);
    check("areset.alu_a", 64'(bus.alu_a), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("areset.idle", 64'({bus.busy, bus.done}), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
